// File: rtl/qaccum_if.sv
// Valid/ready data channel shared by the qaccum input and output sides.
// Latency: none (wires only).
// Backpressure: the data source holds valid/data until it samples ready high.
interface qaccum_if #(
    parameter int W = 8
);
    logic         valid;
    logic         ready;
    logic [W-1:0] data;

    // Data source side (the "producer" role of the channel).
    modport master (output valid, output data, input ready);
    // Data sink side (the "consumer" role of the channel).
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/qaccum.sv
// Reduces each inner sub-transaction on din to one {eot, count, sum} item on dout.
// Latency: dout.valid rises one cycle after the terminal din item is accepted.
// Backpressure: only terminal din items stall, and only while a result is waiting on a stalled dout.
module qaccum #(
    parameter int W_DATA = 16,
    parameter int W_ACC  = 24,
    parameter int W_CNT  = 8
) (
    input  logic    clk,
    input  logic    rst,
    qaccum_if.slave  din,
    qaccum_if.master dout
);
    // din.data layout: {eot[1:0], data[W_DATA-1:0]}
    logic [1:0]        in_eot;
    logic [W_DATA-1:0] in_data;
    logic              in_last;
    logic              din_xfer;
    logic              dout_xfer;

    logic [W_ACC-1:0]  acc_reg;
    logic [W_CNT-1:0]  cnt_reg;
    logic              out_eot;
    logic [W_CNT-1:0]  out_cnt;
    logic [W_ACC-1:0]  out_sum;
    logic              out_valid;

    // Sum and count of the sub-transaction including the current item.
    logic [W_ACC-1:0]  acc_next;
    logic [W_CNT-1:0]  cnt_next;

    assign in_eot  = din.data[W_DATA+1:W_DATA];
    assign in_data = din.data[W_DATA-1:0];

    // Only eot[0] closes a sub-transaction; an outer end without an inner
    // end (eot=2'b10) is therefore handled as an ordinary middle item.
    assign in_last = in_eot[0];

    // A terminal item needs the output register: it may go in when the
    // register is empty or being drained this very cycle. Middle items
    // never touch the output register and so are never stalled.
    assign din.ready = ~in_last | ~out_valid | dout.ready;

    assign din_xfer  = din.valid & din.ready;
    assign dout_xfer = out_valid & dout.ready;

    // Modular adders: wrap silently at 2^W_ACC and 2^W_CNT.
    assign acc_next = acc_reg + W_ACC'(in_data);
    assign cnt_next = cnt_reg + W_CNT'(1);

    // Running partial sum/count of the open sub-transaction; cleared when it closes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_reg <= '0;
            cnt_reg <= '0;
        end else if (din_xfer) begin
            if (in_last) begin
                acc_reg <= '0;
                cnt_reg <= '0;
            end else begin
                acc_reg <= acc_next;
                cnt_reg <= cnt_next;
            end
        end
    end

    // One-entry output register: loads on a closing item, empties on dout accept;
    // a same-cycle load and accept keeps it full for one-per-cycle throughput.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_eot   <= 1'b0;
            out_cnt   <= '0;
            out_sum   <= '0;
            out_valid <= 1'b0;
        end else if (din_xfer && in_last) begin
            out_eot   <= in_eot[1];
            out_cnt   <= cnt_next;
            out_sum   <= acc_next;
            out_valid <= 1'b1;
        end else if (dout_xfer) begin
            out_valid <= 1'b0;
        end
    end

    assign dout.valid = out_valid;
    assign dout.data  = {out_eot, out_cnt, out_sum};
endmodule

// File: tb/tb_qaccum.sv
// Self-checking bench for qaccum (W_DATA=8, W_ACC=12, W_CNT=4): directed
// scenarios followed by random traffic, all compared against a queue-based
// reference model that recomputes each sub-transaction sum from its items.
module tb_qaccum;
    localparam int WD = 8;
    localparam int WA = 12;
    localparam int WC = 4;
    localparam int WO = 1 + WC + WA;

    logic clk = 1'b0;
    logic rst = 1'b1;

    qaccum_if #(.W(WD + 2)) din_if ();
    qaccum_if #(.W(WO))     dout_if ();

    qaccum #(.W_DATA(WD), .W_ACC(WA), .W_CNT(WC)) dut (
        .clk  (clk),
        .rst  (rst),
        .din  (din_if.slave),
        .dout (dout_if.master)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;

    // Reference model: items of the open sub-transaction, plus the one result
    // that should be visible on dout.
    int             open_items[$];
    logic           exp_valid;
    logic [WO-1:0]  exp_item;
    logic           last_acc;

    function automatic logic [WO-1:0] mk(input int e, input int c, input int s);
        logic [WO-1:0] r;
        r = {e[0], c[WC-1:0], s[WA-1:0]};
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        open_items.delete();
        exp_valid = 1'b0;
        exp_item  = '0;
    endtask

    // One clock of stimulus: drive at the falling edge, check ready
    // combinationally, then check dout after the rising edge.
    task automatic step(input logic v, input int d, input logic [1:0] eot, input logic rdy);
        logic exp_rdy;
        logic din_x;
        logic dout_x;
        int   total;
        logic [7:0] d8;
        d8 = d[7:0];
        @(negedge clk);
        din_if.valid  = v;
        din_if.data   = {eot, d8};
        dout_if.ready = rdy;
        #1;
        exp_rdy = !eot[0] || !exp_valid || rdy;
        check("din_ready", {31'd0, din_if.ready}, {31'd0, exp_rdy});
        din_x  = v && exp_rdy;
        dout_x = exp_valid && rdy;
        last_acc = din_x;
        @(posedge clk);
        #1;
        if (dout_x) exp_valid = 1'b0;
        if (din_x) begin
            if (eot[0]) begin
                total = int'(d8);
                foreach (open_items[i]) total += open_items[i];
                exp_item  = mk(int'(eot[1]), (open_items.size() + 1) % 16, total % 4096);
                exp_valid = 1'b1;
                open_items.delete();
            end else begin
                open_items.push_back(int'(d8));
            end
        end
        check("dout_valid", {31'd0, dout_if.valid}, {31'd0, exp_valid});
        if (exp_valid) check("dout_data", {15'd0, dout_if.data}, {15'd0, exp_item});
    endtask

    initial begin
        din_if.valid  = 1'b0;
        din_if.data   = '0;
        dout_if.ready = 1'b0;
        model_reset();
        last_acc = 1'b0;

        // Reset state while rst is high.
        #2;
        check("rst_dout_valid", {31'd0, dout_if.valid}, 32'd0);
        check("rst_dout_data",  {15'd0, dout_if.data},  32'd0);
        check("rst_din_ready",  {31'd0, din_if.ready},  32'd1);
        #10 rst = 1'b0;

        // Basic: 3,5,7 -> {0,3,15}, valid exactly one cycle after the 7.
        step(1, 3, 2'b00, 1);
        step(1, 5, 2'b00, 1);
        step(1, 7, 2'b01, 1);
        check("basic", {15'd0, dout_if.data}, {15'd0, mk(0, 3, 15)});
        step(0, 0, 2'b00, 1);

        // Nested: 1/00, 2/01, 3/11 -> {0,2,3} then {1,1,3}.
        step(1, 1, 2'b00, 1);
        step(1, 2, 2'b01, 1);
        check("nested_a", {15'd0, dout_if.data}, {15'd0, mk(0, 2, 3)});
        step(1, 3, 2'b11, 1);
        check("nested_b", {15'd0, dout_if.data}, {15'd0, mk(1, 1, 3)});
        step(0, 0, 2'b00, 1);

        // Backpressure: result held, 9/00 still accepted, 4/01 stalled until ready.
        step(1, 8, 2'b01, 0);
        step(1, 9, 2'b00, 0);
        check("bp_9_acc", {31'd0, last_acc}, 32'd1);
        step(1, 4, 2'b01, 0);
        check("bp_4_stall", {31'd0, din_if.ready}, 32'd0);
        check("bp_hold", {15'd0, dout_if.data}, {15'd0, mk(0, 1, 8)});
        step(1, 4, 2'b01, 1);
        check("bp_4_acc", {31'd0, last_acc}, 32'd1);
        check("bp_result", {15'd0, dout_if.data}, {15'd0, mk(0, 2, 13)});
        step(0, 0, 2'b00, 1);

        // Wrap: 17 x 255 -> cnt 1, sum 239.
        for (int i = 0; i < 17; i++) step(1, 255, (i == 16) ? 2'b01 : 2'b00, 1);
        check("wrap", {15'd0, dout_if.data}, {15'd0, mk(0, 1, 239)});
        step(0, 0, 2'b00, 1);

        // Reset mid-operation with a result pending: valid drops at once.
        step(1, 6, 2'b01, 0);
        step(1, 10, 2'b00, 0);
        step(1, 20, 2'b00, 0);
        din_if.valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("async_rst_valid", {31'd0, dout_if.valid}, 32'd0);
        check("async_rst_ready", {31'd0, din_if.ready},  32'd1);
        model_reset();
        #2 rst = 1'b0;
        step(1, 5, 2'b01, 1);
        check("post_rst", {15'd0, dout_if.data}, {15'd0, mk(0, 1, 5)});

        // Throughput: single-item sub-transactions every cycle.
        step(1, 1, 2'b01, 1);
        check("tp_a", {15'd0, dout_if.data}, {15'd0, mk(0, 1, 1)});
        step(1, 2, 2'b01, 1);
        check("tp_b", {15'd0, dout_if.data}, {15'd0, mk(0, 1, 2)});
        step(1, 3, 2'b11, 1);
        check("tp_c", {15'd0, dout_if.data}, {15'd0, mk(1, 1, 3)});
        step(0, 0, 2'b00, 1);

        // Random traffic, including the illegal eot=2'b10 as a middle item.
        for (int i = 0; i < 400; i++) begin
            logic [1:0] e;
            int sel;
            sel = int'($urandom_range(0, 9));
            e = (sel < 5) ? 2'b00 : (sel < 8) ? 2'b01 : (sel < 9) ? 2'b11 : 2'b10;
            step(logic'($urandom_range(0, 3) != 0), int'($urandom_range(0, 255)), e,
                 logic'($urandom_range(0, 2) != 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule

// File: doc/qaccum.md
QACCUM -- requirements
Module: qaccum

Interface
REQ-001 Parameter W_DATA, default 16, SHALL be the width of the din payload excluding eot bits.
REQ-002 Parameter W_ACC, default 24, SHALL be the width of the sum field; W_ACC >= W_DATA.
REQ-003 Parameter W_CNT, default 8, SHALL be the width of the element-count field.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst  input  1  SHALL be an asynchronous, active-high reset.
REQ-006 din  dti.consumer  W_DATA+2  SHALL carry {eot[1:0], data[W_DATA-1:0]}; eot[1] is outer end-of-transaction, eot[0] is inner (sub-transaction) end.
REQ-007 dout  dti.producer  1+W_CNT+W_ACC  SHALL carry {eot, cnt[W_CNT-1:0], sum[W_ACC-1:0]}; eot is the MSB.

Function
REQ-008 The block SHALL reduce each inner sub-transaction of din to one dout item: the sum of its data values and its element count.
REQ-009 Handshake: a transfer SHALL occur on a channel when valid & ready in the same cycle; dout.valid and dout.data SHALL be driven only from registers.
REQ-010 State: acc_reg (W_ACC), cnt_reg (W_CNT), a one-entry output register {out_eot, out_cnt, out_sum}, and out_valid.
REQ-011 Non-terminal din item (eot[0]=0) on handshake: acc_reg <= acc_reg + zero-extended data; cnt_reg <= cnt_reg + 1; no output.
REQ-012 Terminal din item (eot[0]=1) on handshake: out_sum <= acc_reg + data; out_cnt <= cnt_reg + 1; out_eot <= eot[1]; out_valid <= 1; acc_reg <= 0; cnt_reg <= 0.
REQ-013 Arithmetic SHALL be unsigned and SHALL wrap modulo 2^W_ACC (sum) and 2^W_CNT (count); no saturation, no overflow flag.
REQ-014 din.ready SHALL equal ~din.eot[0] | ~out_valid | dout.ready; non-terminal items are never stalled.
REQ-015 Latency: dout.valid SHALL assert the cycle after the terminal din handshake.
REQ-016 On dout handshake without a simultaneous terminal din handshake, out_valid SHALL clear.
REQ-017 On a dout handshake and a terminal din handshake in the same cycle, the output register SHALL reload and out_valid SHALL stay 1; sustained throughput SHALL be one sub-transaction per cycle.
REQ-018 Once asserted, dout.valid SHALL remain asserted and dout.data SHALL remain stable until the dout handshake.
REQ-019 A single-element sub-transaction (first item has eot[0]=1) SHALL output sum=data, cnt=1.
REQ-020 din with eot=2'b10 (outer end without inner end) is illegal input; behaviour is unspecified and the block SHALL treat it as non-terminal.
REQ-021 The block SHALL not inspect din.data while din.valid=0, except combinationally in din.ready per REQ-014.

Reset
REQ-022 On rst assertion, acc_reg, cnt_reg, out_sum, out_cnt, out_eot and out_valid SHALL go to 0 immediately, without waiting for a clk edge.
REQ-023 Reset mid-sub-transaction SHALL discard the partial sum; the first item after reset release SHALL start a new sub-transaction.
REQ-024 While rst is high, dout.valid SHALL be 0; din.ready follows REQ-014 with out_valid=0.

Verification (W_DATA=8, W_ACC=12, W_CNT=4)
REQ-025 Basic: din 3/00, 5/00, 7/01, dout.ready=1 -> one dout {eot=0, cnt=3, sum=15}, valid exactly one cycle after the 7 is accepted.
REQ-026 Nested: din 1/00, 2/01, 3/11 -> dout {0,2,3} then {1,1,3}.
REQ-027 Backpressure: out_valid=1, dout.ready=0, din 9/00 then 4/01 -> 9 accepted; din.ready=0 while 4/01 is presented; 4/01 accepted the cycle dout.ready=1; next dout {0,2,13}.
REQ-028 Wrap: 17 items of 255, last with eot=01 -> dout {0, cnt=1, sum=239} (4335 mod 4096, 17 mod 16).
REQ-029 Reset mid-operation: 10/00, 20/00 accepted, rst pulsed asynchronously -> dout.valid drops at once; then 5/01 -> dout {0,1,5}.
REQ-030 Throughput: back-to-back single items 1/01, 2/01, 3/11 every cycle, dout.ready=1 -> dout {0,1,1}, {0,1,2}, {1,1,3} on consecutive cycles, din.ready held at 1.
